action_sequencer: RTL and testbench

ACTION_SEQUENCER -- requirements
Module: action_sequencer

---
 rtl/action_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_action_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/action_sequencer.sv
// action_sequencer: buffers one action per player and issues both actions to
// the downstream fighting-game block as a timed round (enable window + gap).
// Optional feature: define ACTION_TIMEOUT_EN to substitute IDLE_ACTION for a
// player who has not submitted TIMEOUT_CYCLES cycles after the other did.
module action_sequencer #(
  parameter int         ENABLE_CYCLES  = 2,
  parameter int         GAP_CYCLES     = 1,
  parameter int         TIMEOUT_CYCLES = 15,
  parameter logic [2:0] IDLE_ACTION    = 3'b000
) (
  input  logic       clk,
  input  logic       resetGame,
  input  logic       btnValid1,
  input  logic       btnValid2,
  input  logic [2:0] btnAction1,
  input  logic [2:0] btnAction2,
  input  logic       gameOver,
  output logic [2:0] action1,
  output logic [2:0] action2,
  output logic       actionEnable,
  output logic       ready1,
  output logic       ready2,
  output logic [7:0] roundCount
);

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_GAP     = 2'd2;
  localparam logic [1:0] S_HALT    = 2'd3;

  // One counter width serves the enable/gap window and the timeout wait.
  localparam int MAX_A   = (ENABLE_CYCLES > GAP_CYCLES) ? ENABLE_CYCLES : GAP_CYCLES;
  localparam int MAX_CYC = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  logic [1:0]    state_q, state_d;
  logic          slot1_full_q, slot1_full_d, slot2_full_q, slot2_full_d;
  logic [2:0]    slot1_val_q, slot1_val_d, slot2_val_q, slot2_val_d;
  logic [2:0]    act1_q, act1_d, act2_q, act2_d;
  logic          en_q, en_d;
  logic          rdy1_q, rdy1_d, rdy2_q, rdy2_d;
  logic [7:0]    round_q, round_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          halt_pend_q, halt_pend_d;
`ifdef ACTION_TIMEOUT_EN
  logic [CW-1:0] tmo_q, tmo_d;
`endif

  logic       acc1, acc2, issue;
  logic [2:0] iss1, iss2;

  // Next-state logic: slot acceptance, round sequencing and halt handling.
  // NOTE: every signal gets a default at the top so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    act1_d      = act1_q;
    act2_d      = act2_q;
    round_d     = round_q;
    cnt_d       = cnt_q;
    halt_pend_d = halt_pend_q;
`ifdef ACTION_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif
    issue = 1'b0;

    // Ready flops already encode "slot empty and not halted".
    acc1 = btnValid1 && rdy1_q;
    acc2 = btnValid2 && rdy2_q;
    slot1_full_d = slot1_full_q || acc1;
    slot2_full_d = slot2_full_q || acc2;
    slot1_val_d  = acc1 ? btnAction1 : slot1_val_q;
    slot2_val_d  = acc2 ? btnAction2 : slot2_val_q;
    iss1 = slot1_val_d;
    iss2 = slot2_val_d;

    case (state_q)
      S_COLLECT: begin
        // Issuing on the accepting edge makes actionEnable rise one cycle
        // after the second acceptance.
        if (gameOver) begin
          state_d = S_HALT;
        end else if (slot1_full_d && slot2_full_d) begin
          issue = 1'b1;
`ifdef ACTION_TIMEOUT_EN
        end else if (slot1_full_q ^ slot2_full_q) begin
          if (tmo_q == CW'(TIMEOUT_CYCLES - 1)) begin
            issue = 1'b1;
            if (!slot1_full_d) iss1 = IDLE_ACTION;
            if (!slot2_full_d) iss2 = IDLE_ACTION;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
`endif
        end
      end
      S_ISSUE: begin
        // A win seen anywhere in the window is remembered until it closes.
        if (gameOver) halt_pend_d = 1'b1;
        if (cnt_q == CW'(ENABLE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = (gameOver || halt_pend_q) ? S_HALT : S_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gameOver) begin
          state_d = S_HALT;
        end else if (cnt_q == CW'(GAP_CYCLES - 1)) begin
          cnt_d = '0;
          if (slot1_full_d && slot2_full_d) issue = 1'b1;
          else state_d = S_COLLECT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase

    if (issue) begin
      state_d      = S_ISSUE;
      cnt_d        = '0;
      act1_d       = iss1;
      act2_d       = iss2;
      slot1_full_d = 1'b0;
      slot2_full_d = 1'b0;
      round_d      = round_q + 8'd1;
      halt_pend_d  = 1'b0;
`ifdef ACTION_TIMEOUT_EN
      tmo_d        = '0;
`endif
    end

    if (state_d == S_HALT) begin
      slot1_full_d = 1'b0;
      slot2_full_d = 1'b0;
    end

    en_d   = (state_d == S_ISSUE);
    rdy1_d = !slot1_full_d && (state_d != S_HALT);
    rdy2_d = !slot2_full_d && (state_d != S_HALT);
  end

  // State and registered outputs; resetGame clears everything immediately.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge resetGame) begin
    if (resetGame) begin
      state_q      <= S_COLLECT;
      slot1_full_q <= 1'b0;
      slot2_full_q <= 1'b0;
      slot1_val_q  <= IDLE_ACTION;
      slot2_val_q  <= IDLE_ACTION;
      act1_q       <= IDLE_ACTION;
      act2_q       <= IDLE_ACTION;
      en_q         <= 1'b0;
      rdy1_q       <= 1'b1;
      rdy2_q       <= 1'b1;
      round_q      <= 8'd0;
      cnt_q        <= '0;
      halt_pend_q  <= 1'b0;
`ifdef ACTION_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      slot1_full_q <= slot1_full_d;
      slot2_full_q <= slot2_full_d;
      slot1_val_q  <= slot1_val_d;
      slot2_val_q  <= slot2_val_d;
      act1_q       <= act1_d;
      act2_q       <= act2_d;
      en_q         <= en_d;
      rdy1_q       <= rdy1_d;
      rdy2_q       <= rdy2_d;
      round_q      <= round_d;
      cnt_q        <= cnt_d;
      halt_pend_q  <= halt_pend_d;
`ifdef ACTION_TIMEOUT_EN
      tmo_q        <= tmo_d;
`endif
    end
  end

  assign action1      = act1_q;
  assign action2      = act2_q;
  assign actionEnable = en_q;
  assign ready1       = rdy1_q;
  assign ready2       = rdy2_q;
  assign roundCount   = round_q;

endmodule

// File: tb/tb_action_sequencer.sv
// tb_action_sequencer: directed and random stimulus against a round-level
// reference model of the action sequencer (default parameters).
module tb_action_sequencer;

  localparam int         EN_CYC = 2;
  localparam int         GP_CYC = 1;
  localparam int         TO_CYC = 15;
  localparam logic [2:0] IDLE   = 3'b000;

  logic       clk = 1'b0;
  logic       resetGame = 1'b1;
  logic       bv1 = 1'b0, bv2 = 1'b0, go = 1'b0;
  logic [2:0] ba1 = 3'b0, ba2 = 3'b0;
  logic [2:0] action1, action2;
  logic       actionEnable, ready1, ready2;
  logic [7:0] roundCount;

  always #5 clk = ~clk;

  action_sequencer dut (
    .clk(clk), .resetGame(resetGame),
    .btnValid1(bv1), .btnValid2(bv2),
    .btnAction1(ba1), .btnAction2(ba2),
    .gameOver(go),
    .action1(action1), .action2(action2),
    .actionEnable(actionEnable),
    .ready1(ready1), .ready2(ready2),
    .roundCount(roundCount)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: what the players have handed in, what was last shown,
  // and how many cycles remain in the current window.
  typedef enum {M_WAIT, M_SHOW, M_PAUSE, M_OVER} mode_t;
  mode_t      m_mode;
  int         m_left, m_waited, m_rounds;
  bit         m_pend, m_has1, m_has2;
  logic [2:0] m_v1, m_v2, m_a1, m_a2;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_WAIT; m_left = 0; m_waited = 0; m_rounds = 0; m_pend = 0;
    m_has1 = 0; m_has2 = 0; m_v1 = IDLE; m_v2 = IDLE; m_a1 = IDLE; m_a2 = IDLE;
  endtask

  task automatic model_issue(input logic [2:0] x1, input logic [2:0] x2);
    m_a1 = x1; m_a2 = x2; m_has1 = 0; m_has2 = 0;
    m_rounds = (m_rounds + 1) % 256;
    m_mode = M_SHOW; m_left = EN_CYC; m_waited = 0; m_pend = 0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    bit had1, had2;
    if (resetGame) begin model_reset(); return; end
    if (m_mode == M_OVER) return;
    had1 = m_has1; had2 = m_has2;
    if (bv1 && !m_has1) begin m_has1 = 1; m_v1 = ba1; end
    if (bv2 && !m_has2) begin m_has2 = 1; m_v2 = ba2; end
    case (m_mode)
      M_WAIT: begin
        if (go) m_mode = M_OVER;
        else if (m_has1 && m_has2) model_issue(m_v1, m_v2);
`ifdef ACTION_TIMEOUT_EN
        else if (had1 != had2) begin
          m_waited++;
          if (m_waited == TO_CYC)
            model_issue(m_has1 ? m_v1 : IDLE, m_has2 ? m_v2 : IDLE);
        end
`endif
      end
      M_SHOW: begin
        if (go) m_pend = 1;
        m_left--;
        if (m_left == 0) begin
          if (m_pend) m_mode = M_OVER;
          else begin m_mode = M_PAUSE; m_left = GP_CYC; end
        end
      end
      M_PAUSE: begin
        if (go) m_mode = M_OVER;
        else begin
          m_left--;
          if (m_left == 0) begin
            if (m_has1 && m_has2) model_issue(m_v1, m_v2);
            else m_mode = M_WAIT;
          end
        end
      end
      default: ;
    endcase
    if (m_mode == M_OVER) begin m_has1 = 0; m_has2 = 0; end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_action1"}, {5'b0, action1}, {5'b0, m_a1});
    check({tag, "_action2"}, {5'b0, action2}, {5'b0, m_a2});
    check({tag, "_enable"}, {7'b0, actionEnable}, {7'b0, m_mode == M_SHOW});
    check({tag, "_ready1"}, {7'b0, ready1}, {7'b0, !m_has1 && m_mode != M_OVER});
    check({tag, "_ready2"}, {7'b0, ready2}, {7'b0, !m_has2 && m_mode != M_OVER});
    check({tag, "_rounds"}, roundCount, 8'(m_rounds));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic v1, input logic [2:0] a1,
                       input logic v2, input logic [2:0] a2, input logic g);
    bv1 = v1; ba1 = a1; bv2 = v2; ba2 = a2; go = g;
  endtask

  task automatic idle();
    drive(0, 3'b0, 0, 3'b0, 0);
  endtask

  // Run idle cycles until the model is collecting again (bounded).
  task automatic settle(input string tag);
    idle();
    for (int i = 0; i < 10 && m_mode != M_WAIT; i++) cycle(tag);
  endtask

  initial begin
    int   cnt, over_cnt;
    bit   wrap_seen;
    logic [7:0] prev_round;

    // Reset state while reset is held.
    model_reset();
    @(posedge clk); #1;
    check_all("reset");
    resetGame = 0;

    // Player 1 at cycle 0, player 2 at cycle 3.
    drive(1, 3'b100, 0, 3'b0, 0); cycle("r31_c0");
    idle();                       cycle("r31_c1");
                                  cycle("r31_c2");
    drive(0, 3'b0, 1, 3'b110, 0); cycle("r31_c3");
    check("r31_en_c4", {7'b0, actionEnable}, 8'd1);
    check("r31_a1", {5'b0, action1}, 8'b100);
    check("r31_a2", {5'b0, action2}, 8'b110);
    idle();                       cycle("r31_c4");
    check("r31_en_c5", {7'b0, actionEnable}, 8'd1);
                                  cycle("r31_c5");
    check("r31_en_c6", {7'b0, actionEnable}, 8'd0);
    check("r31_rounds", roundCount, 8'd1);
    settle("r31_settle");

    // Both players in the same cycle.
    drive(1, 3'b110, 1, 3'b100, 0); cycle("r32_c0");
    idle(); cycle("r32_c1"); cycle("r32_c2");
    settle("r32_settle");

    // Player 1 strobes twice; the second strobe must be dropped.
    drive(1, 3'b010, 0, 3'b0, 0); cycle("r33_c0");
    check("r33_ready1_low", {7'b0, ready1}, 8'd0);
    drive(1, 3'b111, 0, 3'b0, 0); cycle("r33_c1");
    drive(0, 3'b0, 1, 3'b001, 0); cycle("r33_c2");
    check("r33_a1", {5'b0, action1}, 8'b010);
    settle("r33_settle");

    // Only player 1 submits.
    drive(1, 3'b110, 0, 3'b0, 0); cycle("r34_c0");
    idle();
    cnt = 1;
    while (cnt < 100 && !actionEnable) begin cycle("r34_wait"); cnt++; end
`ifdef ACTION_TIMEOUT_EN
    check("r34_timeout_cycles", 8'(cnt), 8'(TO_CYC + 1));
    check("r34_a2_idle", {5'b0, action2}, {5'b0, IDLE});
`else
    check("r34_no_enable", {7'b0, actionEnable}, 8'd0);
    drive(0, 3'b0, 1, 3'b011, 0); cycle("r34_p2");
`endif
    settle("r34_settle");

    // gameOver during the enable window.
    drive(1, 3'b101, 1, 3'b011, 0); cycle("r35_c0");
    drive(0, 3'b0, 0, 3'b0, 1);     cycle("r35_c1");
    idle();                         cycle("r35_c2");
    check("r35_halt_ready1", {7'b0, ready1}, 8'd0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 3'($urandom), 1, 3'($urandom), 0); cycle("r35_ignored");
    end
    idle();
    resetGame = 1; cycle("r35_reset");
    resetGame = 0; cycle("r35_after");
    check("r35_rounds_zero", roundCount, 8'd0);

    // Reset mid-ISSUE acts without a clock edge.
    drive(1, 3'b111, 1, 3'b101, 0); cycle("r36_c0");
    idle();
    #2 resetGame = 1;
    #1;
    check("r36_async_en", {7'b0, actionEnable}, 8'd0);
    check("r36_async_a1", {5'b0, action1}, 8'd0);
    check("r36_async_a2", {5'b0, action2}, 8'd0);
    model_reset();
    cycle("r36_hold");
    resetGame = 0;
    cycle("r36_release");

    // Back-to-back rounds until the round counter wraps.
    wrap_seen = 0;
    prev_round = roundCount;
    for (int i = 0; i < 800; i++) begin
      drive(1, 3'($urandom), 1, 3'($urandom), 0);
      cycle("wrap");
      if (prev_round == 8'd255 && roundCount == 8'd0) wrap_seen = 1;
      prev_round = roundCount;
    end
    check("round_wrap_seen", {7'b0, wrap_seen}, 8'd1);
    settle("wrap_settle");

    // Random play with occasional wins and recovery resets.
    over_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      if (m_mode == M_OVER) over_cnt++; else over_cnt = 0;
      resetGame = (over_cnt > 4);
      drive($urandom_range(0, 2) == 0, 3'($urandom),
            $urandom_range(0, 2) == 0, 3'($urandom),
            $urandom_range(0, 149) == 0);
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
